// File: rtl/clk_divider.sv
// Divide-by-two clock generator with 0/90-degree outputs and matching
// synchronously released active-low resets, cascadable for /4, /8, ...
module clk_divider (
  input  logic clk_i,
  input  logic rst_i,
  input  logic init_i,
  output logic clk0_o,
  output logic clk90_o,
  output logic rst0_o,
  output logic rst90_o
);

  logic sync_q1;
  logic rst_sync;
  logic clk180;
  logic clk270;

  assign clk180 = ~clk0_o;
  assign clk270 = ~clk90_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q1  <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      sync_q1  <= 1'b1;
      rst_sync <= sync_q1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clk0_o <= 1'b0;
    end else if (rst_sync) begin
      clk0_o <= init_i ? clk180 : 1'b0;
    end
  end

  // At every rising edge clk90_o already equals clk0_o (captured on the
  // preceding falling edge), so ~clk270 marks the edge on which clk0_o falls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst0_o <= 1'b0;
    end else if (rst_sync && !clk270) begin
      rst0_o <= 1'b1;
    end
  end

  always_ff @(negedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clk90_o <= 1'b0;
      rst90_o <= 1'b0;
    end else begin
      clk90_o <= clk0_o;
      rst90_o <= rst0_o;
    end
  end

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: single instance against a cycle-rule reference
// model, plus a three-instance cascade for the /4 phase relationships.
module tb_clk_divider;

  logic clk_i = 1'b0;
  logic rst_i;
  logic init_i;
  logic a_clk0, a_clk90, a_rst0, a_rst90;
  logic b_clk0, b_clk90, b_rst0, b_rst90;
  logic c_clk0, c_clk90, c_rst0, c_rst90;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int   m_edges;
  logic m_clk0, m_clk90, m_rst0, m_rst90;

  time  t_b0 = 0, t_b0_prev = 0, t_b90 = 0, t_c0 = 0;
  logic b180_flag = 1'b0;

  always #5 clk_i = ~clk_i;

  clk_divider u_a (
    .clk_i(clk_i), .rst_i(rst_i), .init_i(init_i),
    .clk0_o(a_clk0), .clk90_o(a_clk90), .rst0_o(a_rst0), .rst90_o(a_rst90)
  );

  clk_divider u_b (
    .clk_i(a_clk0), .rst_i(a_rst0), .init_i(1'b1),
    .clk0_o(b_clk0), .clk90_o(b_clk90), .rst0_o(b_rst0), .rst90_o(b_rst90)
  );

  clk_divider u_c (
    .clk_i(a_clk90), .rst_i(a_rst90), .init_i(1'b1),
    .clk0_o(c_clk0), .clk90_o(c_clk90), .rst0_o(c_rst0), .rst90_o(c_rst90)
  );

  always @(posedge b_clk0) begin
    t_b0_prev = t_b0;
    t_b0      = $time;
  end
  always @(posedge b_clk90) t_b90 = $time;
  always @(posedge c_clk0)  t_c0  = $time;
  always @(posedge clk_i) if (u_b.clk180 === 1'b1) b180_flag = 1'b1;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_t(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_clk0  = 1'b0;
    m_clk90 = 1'b0;
    m_rst0  = 1'b0;
    m_rst90 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clk0"},  a_clk0,  1'b0);
    check({tag, "_clk90"}, a_clk90, 1'b0);
    check({tag, "_rst0"},  a_rst0,  1'b0);
    check({tag, "_rst90"}, a_rst90, 1'b0);
  endtask

  // One full clk_i cycle: model the rising edge, check, model the falling
  // edge, check. Ends 1 time unit after the falling edge.
  task automatic step();
    @(posedge clk_i);
    if (!rst_i) begin
      model_reset();
    end else begin
      // Output clocks run from the third rising edge after release (P2 on).
      if (m_edges >= 2) begin
        if (m_clk0) m_rst0 = 1'b1;
        m_clk0 = init_i ? ~m_clk0 : 1'b0;
      end
      if (m_edges < 2) m_edges++;
    end
    #1;
    check("pos_clk0",  a_clk0,  m_clk0);
    check("pos_rst0",  a_rst0,  m_rst0);
    check("pos_clk90", a_clk90, m_clk90);
    check("pos_rst90", a_rst90, m_rst90);
    @(negedge clk_i);
    if (!rst_i) begin
      model_reset();
    end else begin
      m_clk90 = m_clk0;
      m_rst90 = m_rst0;
    end
    #1;
    check("neg_clk90",  a_clk90,    m_clk90);
    check("neg_rst90",  a_rst90,    m_rst90);
    check("neg_clk180", u_a.clk180, ~m_clk0);
    check("neg_clk270", u_a.clk270, ~m_clk90);
  endtask

  task automatic release_sequence();
    for (int s = 0; s < 24; s++) begin
      step();
      if (s == 2) begin
        check("p2_clk0_high",  a_clk0,  1'b1);
        check("p2_clk90_high", a_clk90, 1'b1);
        check("p2_rst0_low",   a_rst0,  1'b0);
      end
      if (s == 3) begin
        check("p3_clk0_low",   a_clk0,  1'b0);
        check("p3_rst0_high",  a_rst0,  1'b1);
        check("p3_rst90_high", a_rst90, 1'b1);
      end
    end
  endtask

  initial begin
    rst_i  = 1'b0;
    init_i = 1'b1;
    model_reset();

    for (int i = 0; i < 3; i++) step();
    check_all_zero("in_reset");

    #2 rst_i = 1'b1;
    release_sequence();

    check_t("b_period",     t_b0 - t_b0_prev, 40);
    check_t("b90_lag",      t_b90 - t_b0,     10);
    check_t("c0_lag_b0",    t_c0 - t_b0,      5);
    check("b_clk180_flag",  b180_flag,        1'b1);

    for (int i = 0; i < 40; i++) begin
      init_i = ($urandom_range(0, 3) != 0);
      step();
    end

    init_i = 1'b1;
    begin
      int budget = 6;
      step();
      while (a_clk0 !== 1'b1 && budget > 0) begin
        step();
        budget--;
      end
      check("wait_clk0_high", a_clk0, 1'b1);
    end
    init_i = 1'b0;
    step();
    check("drop_clk0_low",  a_clk0,  1'b0);
    check("drop_clk90_low", a_clk90, 1'b0);
    check("drop_rst0_hold", a_rst0,  1'b1);
    check("drop_rst90_hold", a_rst90, 1'b1);
    step();
    step();
    check("park_clk0_low", a_clk0, 1'b0);
    init_i = 1'b1;
    step();
    check("resume_clk0_high", a_clk0, 1'b1);
    step();

    #1 rst_i = 1'b0;
    model_reset();
    #1 check_all_zero("midreset_async");
    @(posedge clk_i);
    #1 check_all_zero("midreset_held");
    #6 rst_i = 1'b1;
    release_sequence();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
